// File: rtl/bus_fabric_if.sv
// Request/response bundle for the peripheral fabric: the CPU native-bus side
// (m_*) and the per-slot peripheral side (s_*).
interface bus_fabric_if #(
  parameter int NUM_SLV = 8
);
  logic                   m_valid;
  logic                   m_ready;
  logic [31:0]            m_addr;
  logic [31:0]            m_wdata;
  logic [3:0]             m_wstrb;
  logic [31:0]            m_rdata;
  logic [NUM_SLV-1:0]     s_valid;
  logic [31:0]            s_addr;
  logic [31:0]            s_wdata;
  logic [3:0]             s_wstrb;
  logic [NUM_SLV-1:0]     s_ready;
  logic [NUM_SLV*32-1:0]  s_rdata;

  // The fabric: answers CPU requests and drives the peripheral request lines.
  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    output m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb
  );

  // The environment around the fabric: the CPU plus the peripherals.
  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    input  m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb
  );
endinterface

// File: rtl/bus_fabric.sv
// Address-decoding fabric between a picorv32-style native bus and up to 16
// peripheral slots, with a timeout watchdog and a small status/error block.
module bus_fabric #(
  parameter int                    NUM_SLV   = 8,
  parameter logic [NUM_SLV*32-1:0] SLV_BASE  = '0,
  parameter logic [NUM_SLV*32-1:0] SLV_MASK  = '0,
  parameter int                    TIMEOUT   = 255,
  parameter logic [31:0]           STAT_BASE = 32'h4000_F000,
  parameter logic [31:0]           ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic         clk,
  input  logic         resetn,
  bus_fabric_if.slave  bus,
  output logic         err_irq
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_STAT   = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  // Last count value still allowed to wait; one more miss means timeout.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]         state_q, state_d;
  logic [NUM_SLV-1:0] sel_q, sel_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               unm_q, unm_d;
  logic               tmo_q, tmo_d;
  logic               wflag_q, wflag_d;
  logic [31:0]        err_addr_q, err_addr_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic [NUM_SLV-1:0] hit;
  logic [NUM_SLV-1:0] hit_first;
  logic               stat_hit;
  logic               sel_ready;
  logic [31:0]        sel_rdata;
  logic [31:0]        stat_rdata;
  logic [31:0]        rdata_term [NUM_SLV];
  logic               err_event;
  logic               err_is_tmo;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLV; gi++) begin : g_slot
      localparam logic [31:0] BASE = SLV_BASE[32*gi +: 32];
      localparam logic [31:0] MASK = SLV_MASK[32*gi +: 32];
      // A zero mask would match everything, so it is treated as "slot off".
      assign hit[gi]        = (MASK != 32'd0) && ((bus.m_addr & MASK) == (BASE & MASK));
      assign rdata_term[gi] = sel_q[gi] ? bus.s_rdata[32*gi +: 32] : 32'd0;
    end
  endgenerate

  assign stat_hit  = (bus.m_addr[31:4] == STAT_BASE[31:4]);
  assign sel_ready = |(bus.s_ready & sel_q);
  assign err_irq   = unm_q | tmo_q;

  assign bus.s_addr  = bus.m_addr;
  assign bus.s_wdata = bus.m_wdata;
  assign bus.s_wstrb = bus.m_wstrb;

  // Pick the lowest-index hitting slot and merge the selected slave's read data.
  always_comb begin
    hit_first = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_first    = '0;
        hit_first[i] = 1'b1;
      end
    end
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel_rdata = sel_rdata | rdata_term[i];
    end
  end

  // Status block read mux, word selected by address bits [3:2].
  always_comb begin
    case (bus.m_addr[3:2])
      2'd0:    stat_rdata = {29'd0, wflag_q, tmo_q, unm_q};
      2'd1:    stat_rdata = err_addr_q;
      2'd2:    stat_rdata = {24'd0, err_cnt_q};
      default: stat_rdata = {16'd0, 8'(NUM_SLV), 8'h01};
    endcase
  end

  // Bus outputs are pure functions of state, so reset silences them at once.
  always_comb begin
    bus.s_valid = (state_q == ST_ACTIVE) ? (sel_q & {NUM_SLV{bus.m_valid}}) : '0;
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
    case (state_q)
      ST_ACTIVE: begin
        if (bus.m_valid && sel_ready) begin
          bus.m_ready = 1'b1;
          bus.m_rdata = sel_rdata;
        end
      end
      ST_STAT: begin
        bus.m_ready = 1'b1;
        bus.m_rdata = stat_rdata;
      end
      ST_ERR: begin
        bus.m_ready = 1'b1;
        bus.m_rdata = ERR_RDATA;
      end
      default: ;
    endcase
  end

  // Next-state logic: decode, wait/timeout, status access and error capture.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    unm_d      = unm_q;
    tmo_d      = tmo_q;
    wflag_d    = wflag_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    err_event  = 1'b0;
    err_is_tmo = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.m_valid) begin
          if (stat_hit) begin
            state_d = ST_STAT;
          end else if (|hit) begin
            state_d = ST_ACTIVE;
            sel_d   = hit_first;
            cnt_d   = '0;
          end else begin
            state_d   = ST_ERR;
            err_event = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (!bus.m_valid) begin
          state_d = ST_IDLE;
          sel_d   = '0;
        end else if (sel_ready) begin
          state_d = ST_IDLE;
          sel_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d    = ST_ERR;
          sel_d      = '0;
          err_event  = 1'b1;
          err_is_tmo = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_STAT: begin
        state_d = ST_IDLE;
        if (bus.m_valid && (|bus.m_wstrb)) begin
          if (bus.m_addr[3:2] == 2'd0) begin
            unm_d = 1'b0;
            tmo_d = 1'b0;
          end
          if (bus.m_addr[3:2] == 2'd2) begin
            err_cnt_d = 8'd0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Applied last so a fresh error always overrides a clear in the same cycle.
    if (err_event) begin
      if (err_is_tmo) tmo_d = 1'b1;
      else            unm_d = 1'b1;
      err_addr_d = bus.m_addr;
      wflag_d    = |bus.m_wstrb;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      cnt_q      <= '0;
      unm_q      <= 1'b0;
      tmo_q      <= 1'b0;
      wflag_q    <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      unm_q      <= unm_d;
      tmo_q      <= tmo_d;
      wflag_q    <= wflag_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// Randomized bench for bus_fabric: a transaction-level model predicts every
// cycle's outputs; directed cases pin the model with literal values.
module tb_bus_fabric;

  localparam int NS = 6;
  localparam int TO = 4;
  localparam logic [31:0] STAT_B = 32'h4000_F000;
  localparam logic [31:0] ERR_RD = 32'hDEAD_BEEF;
  // slot5 (disabled) .. slot0
  localparam logic [NS*32-1:0] BASE_P = {32'h5000_0000, 32'h4000_0000, 32'h2000_0000,
                                         32'h4000_1000, 32'h3000_0000, 32'h2000_0000};
  localparam logic [NS*32-1:0] MASK_P = {32'h0000_0000, 32'hFFFF_0000, 32'hFF00_0000,
                                         32'hFFFF_F000, 32'hFFF0_0000, 32'hFFFF_0000};
  localparam int T_UNM  = -1;
  localparam int T_STAT = -2;

  logic clk;
  logic resetn;
  logic err_irq;

  bus_fabric_if #(.NUM_SLV(NS)) bus ();

  bus_fabric #(
    .NUM_SLV  (NS),
    .SLV_BASE (BASE_P),
    .SLV_MASK (MASK_P),
    .TIMEOUT  (TO),
    .STAT_BASE(STAT_B),
    .ERR_RDATA(ERR_RD)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave),
    .err_irq(err_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  logic          chk_en;
  logic [NS-1:0] exp_s_valid;
  logic          exp_m_ready;
  logic [31:0]   exp_m_rdata;
  logic [31:0]   obs_rdata;
  logic [NS-1:0] obs_svalid;

  // Behavioural model of the status block
  logic        md_unm, md_tmo, md_wf;
  logic [31:0] md_eaddr;
  int          md_ecnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    md_unm = 1'b0; md_tmo = 1'b0; md_wf = 1'b0; md_eaddr = '0; md_ecnt = 0;
  endtask

  task automatic model_error(input logic [31:0] a, input logic [3:0] ws, input logic is_tmo);
    if (is_tmo) md_tmo = 1'b1;
    else        md_unm = 1'b1;
    md_eaddr = a;
    md_wf    = (ws != 4'h0);
    if (md_ecnt < 255) md_ecnt++;
  endtask

  task automatic model_stat_write(input logic [31:0] a, input logic [3:0] ws);
    if (ws != 4'h0) begin
      if (a[3:2] == 2'd0) begin md_unm = 1'b0; md_tmo = 1'b0; end
      if (a[3:2] == 2'd2) md_ecnt = 0;
    end
  endtask

  function automatic logic [31:0] stat_word(input logic [1:0] w);
    case (w)
      2'd0:    return {29'd0, md_wf, md_tmo, md_unm};
      2'd1:    return md_eaddr;
      2'd2:    return {24'd0, 8'(md_ecnt)};
      default: return {16'd0, 8'(NS), 8'h01};
    endcase
  endfunction

  // Status block first, then the first enabled slot whose masked bits agree.
  function automatic int decode(input logic [31:0] a);
    logic [31:0] b, m;
    if (a[31:4] == STAT_B[31:4]) return T_STAT;
    for (int i = 0; i < NS; i++) begin
      b = BASE_P[32*i +: 32];
      m = MASK_P[32*i +: 32];
      if (m != 32'd0 && ((a ^ b) & m) == 32'd0) return i;
    end
    return T_UNM;
  endfunction

  task automatic set_exp(input logic [NS-1:0] sv, input logic rdy, input logic [31:0] rd);
    exp_s_valid = sv; exp_m_ready = rdy; exp_m_rdata = rd;
  endtask

  // Random ready/data on all slaves; the selected one follows its schedule.
  task automatic drive_slaves(input int sel, input logic sel_rdy);
    bus.s_ready = NS'($urandom);
    if (sel >= 0) bus.s_ready[sel] = sel_rdy;
    for (int i = 0; i < NS; i++) bus.s_rdata[32*i +: 32] = $urandom;
  endtask

  task automatic compare_cycle();
    check("s_valid", 32'(bus.s_valid), 32'(exp_s_valid));
    check("m_ready", 32'(bus.m_ready), 32'(exp_m_ready));
    if (exp_m_ready) begin
      check("m_rdata", bus.m_rdata, exp_m_rdata);
      obs_rdata = bus.m_rdata;
    end
    if (exp_s_valid != '0) obs_svalid = bus.s_valid;
    check("err_irq", 32'(err_irq), 32'(md_unm | md_tmo));
    check("s_addr", bus.s_addr, bus.m_addr);
    check("s_wdata", bus.s_wdata, bus.m_wdata);
    check("s_wstrb", 32'(bus.s_wstrb), 32'(bus.m_wstrb));
  endtask

  task automatic step();
    @(negedge clk);
    if (chk_en) compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.m_valid = 1'b0;
      drive_slaves(-1, 1'b0);
      set_exp('0, 1'b0, '0);
      step();
    end
  endtask

  // lat: slave-ready cycle (1..TO) or 0 for a slave that never answers.
  // abrt: ACTIVE cycle at which m_valid drops (0 = never).
  task automatic txn(input logic [31:0] addr, input logic [3:0] ws, input int lat,
                     input int abrt, output logic [31:0] rd);
    int tgt;
    logic [NS-1:0] oh;
    tgt = decode(addr);
    obs_svalid = '0;
    obs_rdata  = '0;
    bus.m_valid = 1'b1;
    bus.m_addr  = addr;
    bus.m_wdata = $urandom;
    bus.m_wstrb = ws;
    drive_slaves(-1, 1'b0);
    set_exp('0, 1'b0, '0);
    step();
    if (tgt == T_STAT) begin
      drive_slaves(-1, 1'b0);
      set_exp('0, 1'b1, stat_word(addr[3:2]));
      step();
      model_stat_write(addr, ws);
    end else if (tgt == T_UNM) begin
      model_error(addr, ws, 1'b0);
      drive_slaves(-1, 1'b0);
      set_exp('0, 1'b1, ERR_RD);
      step();
    end else begin
      oh = '0;
      oh[tgt] = 1'b1;
      for (int j = 1; j <= TO + 1; j++) begin
        drive_slaves(tgt, (j == lat));
        if (abrt == j) begin
          bus.m_valid = 1'b0;
          set_exp('0, 1'b0, '0);
          step();
          break;
        end
        if (lat == j) begin
          set_exp(oh, 1'b1, bus.s_rdata[32*tgt +: 32]);
          step();
          break;
        end
        if (j == TO + 1) begin
          model_error(addr, ws, 1'b1);
          set_exp('0, 1'b1, ERR_RD);
          step();
          break;
        end
        set_exp(oh, 1'b0, '0);
        step();
      end
    end
    rd = obs_rdata;
    n_txn++;
    $display("txn %0d addr=%h wstrb=%h tgt=%0d lat=%0d abort=%0d rdata=%h",
             n_txn, addr, ws, tgt, lat, abrt, rd);
  endtask

  task automatic stat_rd(input logic [1:0] w, output logic [31:0] rd);
    txn(STAT_B | 32'({w, 2'b00}), 4'h0, 1, 0, rd);
  endtask

  task automatic stat_wr(input logic [1:0] w);
    logic [31:0] d;
    txn(STAT_B | 32'({w, 2'b00}), 4'hF, 1, 0, d);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [3:0]  ws;
    int lat, abrt, k;

    resetn = 1'b0;
    chk_en = 1'b0;
    bus.m_valid = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_wstrb = '0;
    drive_slaves(-1, 1'b0);
    set_exp('0, 1'b0, '0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_valid", 32'(bus.s_valid), 32'h0);
    check("rst_m_ready", 32'(bus.m_ready), 32'h0);
    check("rst_m_rdata", bus.m_rdata, 32'h0);
    check("rst_err_irq", 32'(err_irq), 32'h0);
    resetn = 1'b1;
    chk_en = 1'b1;
    idle(2);

    stat_rd(2'd3, rd);
    check("lit_version", rd, 32'h0000_0601);

    // Slot 2, ready on third ACTIVE cycle
    txn(32'h4000_1004, 4'h0, 3, 0, rd);
    check("lit_slot2_sel", 32'(obs_svalid), 32'h0000_0004);

    // Reset in the middle of ACTIVE
    bus.m_valid = 1'b1;
    bus.m_addr  = 32'h4000_1004;
    bus.m_wstrb = 4'h0;
    drive_slaves(-1, 1'b0);
    set_exp('0, 1'b0, '0);
    step();
    drive_slaves(2, 1'b0);
    set_exp(6'b000100, 1'b0, '0);
    step();
    drive_slaves(2, 1'b0);
    #2;
    chk_en = 1'b0;
    resetn = 1'b0;
    #1;
    check("rstmid_s_valid", 32'(bus.s_valid), 32'h0);
    check("rstmid_m_ready", 32'(bus.m_ready), 32'h0);
    check("rstmid_m_rdata", bus.m_rdata, 32'h0);
    check("rstmid_err_irq", 32'(err_irq), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    bus.m_valid = 1'b0;
    resetn = 1'b1;
    chk_en = 1'b1;
    idle(1);
    stat_rd(2'd2, rd);
    check("lit_cnt_after_rst", rd, 32'h0);
    txn(32'h4000_1010, 4'h0, 2, 0, rd);
    check("lit_after_rst_sel", 32'(obs_svalid), 32'h0000_0004);

    // Unmapped read (slot 5 is disabled by its zero mask)
    txn(32'h5000_0000, 4'h0, 1, 0, rd);
    check("lit_unm_rdata", rd, 32'hDEAD_BEEF);
    check("lit_irq_set", 32'(err_irq), 32'h1);
    stat_rd(2'd0, rd);
    check("lit_w0_unm", rd, 32'h0000_0001);
    stat_rd(2'd1, rd);
    check("lit_w1_addr", rd, 32'h5000_0000);
    stat_wr(2'd0);
    stat_wr(2'd2);

    // Timeout on a write
    txn(32'h4000_1008, 4'hF, 0, 0, rd);
    check("lit_tmo_rdata", rd, 32'hDEAD_BEEF);
    stat_rd(2'd0, rd);
    check("lit_w0_tmo", rd, 32'h0000_0006);
    stat_rd(2'd2, rd);
    check("lit_cnt_one", rd, 32'h0000_0001);

    // Overlap of slots 0 and 3
    txn(32'h2000_0010, 4'h0, 2, 0, rd);
    check("lit_overlap_sel", 32'(obs_svalid), 32'h0000_0001);

    // Boundary: ready on the last cycle before timeout
    txn(32'h3001_2340, 4'h0, TO, 0, rd);
    check("lit_late_ready_irq", 32'(err_irq), 32'h1);

    // Saturating error counter
    for (int i = 0; i < 300; i++) begin
      txn({4'h6, 28'($urandom)}, 4'($urandom_range(0, 1)), 1, 0, rd);
    end
    stat_rd(2'd2, rd);
    check("lit_cnt_sat", rd, 32'h0000_00FF);
    stat_wr(2'd2);
    stat_rd(2'd2, rd);
    check("lit_cnt_clr", rd, 32'h0);
    stat_wr(2'd0);
    check("lit_irq_clr", 32'(err_irq), 32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      case (k)
        0:       a = {16'h2000, 16'($urandom)};
        1:       a = {8'h20, 8'($urandom_range(1, 255)), 16'($urandom)};
        2:       a = {12'h300, 20'($urandom)};
        3:       a = {20'h40001, 12'($urandom)};
        4:       a = {16'h4000, 4'($urandom_range(2, 14)), 12'($urandom)};
        5, 6:    a = {28'h4000_F00, 2'($urandom), 2'b00};
        7:       a = {4'h5, 28'($urandom)};
        8:       a = {4'h6, 28'($urandom)};
        default: a = $urandom;
      endcase
      ws   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      lat  = $urandom_range(0, TO);
      abrt = 0;
      if ($urandom_range(0, 7) == 0) begin
        if (lat == 0)     abrt = $urandom_range(1, TO - 1);
        else if (lat > 1) abrt = $urandom_range(1, lat - 1);
      end
      txn(a, ws, lat, abrt, rd);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_fabric.md
BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 Parameter NUM_SLV, default 8: number of peripheral slots, range 1..16.
REQ-002 Parameter SLV_BASE, default all-zero: packed NUM_SLV x 32-bit base addresses, slot i at bits [32i+31:32i].
REQ-003 Parameter SLV_MASK, default all-zero: packed NUM_SLV x 32-bit compare masks, same packing; a mask of zero disables that slot.
REQ-004 Parameter TIMEOUT, default 255: cycles to wait for slave ready before error termination, range 1..65535.
REQ-005 Parameter STAT_BASE, default 32'h4000_F000: base of the 4-word internal status block.
REQ-006 Parameter ERR_RDATA, default 32'hDEAD_BEEF: read data returned on an error response.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 resetn  in  1  asynchronous, active-low reset.
REQ-009 m_valid / m_ready  in / out  1 / 1  picorv32 native-bus request and completion.
REQ-010 m_addr, m_wdata  in  32 each  request address and write data.
REQ-011 m_wstrb  in  4  byte write strobes; all-zero means read.
REQ-012 m_rdata  out  32  read data, valid only while m_ready=1.
REQ-013 s_valid  out  NUM_SLV  one-hot slave request.
REQ-014 s_addr, s_wdata, s_wstrb  out  32/32/4  direct copies of m_addr, m_wdata, m_wstrb.
REQ-015 s_ready  in  NUM_SLV  per-slave completion.
REQ-016 s_rdata  in  NUM_SLV*32  packed per-slave read data.
REQ-017 err_irq  out  1  level, high while any sticky error flag is set.

Function
REQ-018 Slot i SHALL hit when (m_addr & mask_i) == (base_i & mask_i) and mask_i != 0; the lowest-index hit SHALL win.
REQ-019 The status block SHALL hit for m_addr[31:4] == STAT_BASE[31:4] and SHALL take priority over all slots.
REQ-020 FSM states SHALL be IDLE, ACTIVE, STAT, ERR.
REQ-021 IDLE with m_valid: slot hit -> ACTIVE, latch one-hot sel; status hit -> STAT; no hit -> ERR with cause UNMAPPED; the decode cycle never asserts m_ready.
REQ-022 s_valid SHALL equal sel & {NUM_SLV{m_valid}} only in ACTIVE; it is zero in all other states.
REQ-023 ACTIVE with s_ready[sel]=1: m_ready=1 and m_rdata=s_rdata[sel] in the same cycle; next state IDLE; s_ready of unselected slaves SHALL be ignored.
REQ-024 ACTIVE timeout counter SHALL clear on entry, increment each cycle without ready, and on reaching TIMEOUT go to ERR with cause TIMEOUT; s_valid drops that cycle.
REQ-025 ERR SHALL assert m_ready for exactly one cycle with m_rdata=ERR_RDATA, any write is discarded, and the FSM returns to IDLE.
REQ-026 STAT SHALL respond in one cycle with m_ready=1 and then return to IDLE.
REQ-027 Status word 0x0 SHALL read {29'b0, write_flag, timeout_sticky, unmapped_sticky}; any write to it clears both sticky bits.
REQ-028 Status word 0x4 SHALL read the address of the most recent error; writes are ignored.
REQ-029 Status word 0x8 SHALL read {24'b0, err_count}, an 8-bit count saturating at 255; any write clears it to zero.
REQ-030 Status word 0xC SHALL read {16'b0, NUM_SLV[7:0], 8'h01 version}.
REQ-031 On entry to ERR: set the cause sticky bit, load err_addr=m_addr and write_flag=|m_wstrb, and increment err_count.
REQ-032 If a clear write and a new error land in the same cycle, the new error SHALL win.
REQ-033 m_valid falling in ACTIVE before ready SHALL abort to IDLE with no error recorded.
REQ-034 Completion latency SHALL be 1 decode cycle plus slave latency; back-to-back requests SHALL re-decode each time.

Reset
REQ-035 Asserting resetn low SHALL immediately force state=IDLE, s_valid=0, m_ready=0, m_rdata=0, sel=0, counter=0, all sticky flags, err_addr and err_count=0, and err_irq=0.
REQ-036 Reset mid-transaction SHALL abandon the transaction silently; no error is recorded.

Verification
REQ-037 Slot 2 base 0x4000_1000, mask 0xFFFF_F000; read 0x4000_1004, slave ready after 3 cycles -> s_valid=0b100 for 3 cycles, m_ready 1 cycle, rdata passed through.
REQ-038 Read 0x5000_0000 with no slot hit -> m_ready on cycle 2, rdata=0xDEAD_BEEF, status word 0x0=0x1, word 0x4=0x5000_0000, err_irq=1.
REQ-039 TIMEOUT=4, slave never ready, write -> s_valid high for 4 cycles, then ERR response; status word 0x0=0x6, err_count=1.
REQ-040 Overlapping slots 0 and 3 both hit -> only s_valid[0] asserts.
REQ-041 Trigger 300 errors -> err_count reads 255; write word 0x8 -> reads 0; write word 0x0 -> err_irq=0.
REQ-042 resetn pulsed low mid-ACTIVE -> s_valid=0 asynchronously, err_count unchanged at 0, next request completes normally.
